// File: rtl/pipe_stage_chain_if.sv
// Valid/ready channel carrying a control bundle and a data bundle.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The master holds valid, ctrl and data steady until that
// edge. ready may depend combinationally on the other side's state.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic register chain of DEPTH stages with per-stage valid bits,
// backpressure, bubble compression and a synchronous flush. The control
// bundle of an empty slot is always zero so bubbles carry no side effects.
module pipe_stage_chain #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_chain_if.slave    up,
  pipe_stage_chain_if.master   down,
  output logic [2:0]           occupancy
);

  // Stage 0 is the input side, stage DEPTH-1 drives the output.
  logic [DEPTH-1:0]  v;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // leave[k]: the slot in stage k moves on (or drains) this cycle.
  // free[k]:  stage k can take a new slot at the coming edge.
  // load[k]:  stage k captures a new slot at the coming edge.
  logic [DEPTH-1:0]  leave;
  logic [DEPTH-1:0]  free;
  logic [DEPTH-1:0]  load;
  logic [CTRL_W-1:0] src_ctrl [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];
  logic              drain;
  logic              accept;

  // Advance network: walk from the output stage back to the input so a
  // drain at the end can ripple free space all the way to in_ready.
  always_comb begin
    leave  = '0;
    free   = '0;
    load   = '0;
    drain  = v[DEPTH-1] & down.ready & ~flush;
    leave[DEPTH-1] = drain;
    free[DEPTH-1]  = ~v[DEPTH-1] | drain;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      leave[k] = v[k] & free[k+1] & ~flush;
      free[k]  = ~v[k] | leave[k];
    end
    up.ready = ~flush & free[0];
    accept   = up.valid & up.ready;
    load[0]  = accept;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = leave[k-1];
    end
  end

  // Source of each stage's next contents: the input port for stage 0,
  // the previous stage otherwise.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      src_ctrl[k] = up.ctrl;
      src_data[k] = up.data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      src_ctrl[k] = ctrl_q[k-1];
      src_data[k] = data_q[k-1];
    end
  end

  // Output side: a flush hides the last stage in the same cycle.
  always_comb begin
    down.valid = v[DEPTH-1] & ~flush;
    down.ctrl  = down.valid ? ctrl_q[DEPTH-1] : '0;
    down.data  = data_q[DEPTH-1];
  end

  // Stage registers and occupancy count. Emptied slots zero their control
  // bits; data is left alone because it is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= '0;
      occupancy <= 3'd0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else if (flush) begin
      v         <= '0;
      occupancy <= 3'd0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          v[k]      <= 1'b1;
          ctrl_q[k] <= src_ctrl[k];
          data_q[k] <= src_data[k];
        end else if (leave[k]) begin
          v[k]      <= 1'b0;
          ctrl_q[k] <= '0;
        end
      end
      case ({accept, drain})
        2'b10:   occupancy <= occupancy + 3'd1;
        2'b01:   occupancy <= occupancy - 3'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised elastic pipeline register chain that generalises the fixed per-signal stage registers between pipeline stages. It carries a configurable control bundle and data bundle through DEPTH register stages with a per-stage valid bit, valid/ready backpressure, bubble compression and a synchronous flush. Control bits are forced to zero on every invalid slot, so bubbles never assert side effects such as RegWrite or HALT downstream.

## Interface
- DATA_W, 16, width of the data bundle (ALU result, memory data, PC+2, Rd, …), 1..64
- CTRL_W, 4, width of the control bundle (RegWrite, MemtoReg, PCS, HALT, …), 1..16
- DEPTH, 1, number of register stages, 1..4
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  upstream slot holds a real instruction
- in_ready  output  1  chain accepts the input this cycle
- in_ctrl  input  CTRL_W  control bundle
- in_data  input  DATA_W  data bundle
- flush  input  1  synchronous kill of all in-flight slots
- out_valid  output  1  last stage holds a real instruction
- out_ready  input  1  downstream consumes the output this cycle
- out_ctrl  output  CTRL_W  control bundle; 0 whenever out_valid=0
- out_data  output  DATA_W  data bundle of the last stage
- occupancy  output  3  number of valid stages, 0..DEPTH

## Operation
- State per stage k (0 = input side, DEPTH-1 = output side): v[k], ctrl[k], data[k].
- Advance rule: stage DEPTH-1 drains when out_valid & out_ready. Stage k is free when v[k]=0 or stage k drains. Stage k-1 moves into stage k when v[k-1]=1 and stage k is free. Stage 0 loads input when in_valid & in_ready.
- in_ready = ~flush & (v[0]=0 | v[0] moves forward this cycle). This is a combinational chain from out_ready.
- Bubble compression: a valid stage advances into an empty downstream stage even while out_ready=0. Holes close; ordering is preserved.
- A stage left empty by a move or a drain clears v to 0 and ctrl to 0. Data holds its last value and is don't-care.
- Accept into stage k copies ctrl and data unchanged; there is no arithmetic on the bundles.
- Flush: priority over everything except rst.
  - In the flush cycle: out_valid=0, out_ctrl=0, in_ready=0. No transfer occurs on either side and the input is dropped.
  - Next edge: all v=0, all ctrl=0, data unchanged, occupancy=0.
- Reset: rst high at an edge sets all v=0, ctrl=0, data=0 and occupancy=0. Reset has priority over flush and handshakes. After reset, in_ready=1 (given flush=0) and out_valid=0.
- occupancy is a registered count of set v bits. It is updated by +1 on accept, −1 on drain, and unchanged on simultaneous accept and drain; it is forced to 0 on flush or rst. It never exceeds DEPTH.
- out_valid = v[DEPTH-1] & ~flush. out_ctrl = out_valid ? ctrl[DEPTH-1] : 0. out_data = data[DEPTH-1].

## Timing
- Latency: DEPTH cycles from the accepting edge to out_valid=1 with no stall (DEPTH=1 gives a single-register stage).
- Throughput: 1 transfer per cycle sustained with out_ready=1. Full with out_ready=0: in_ready=0 once occupancy=DEPTH.
- Full with out_ready=1 in the same cycle: accept and drain both occur, and occupancy is unchanged.
- out_valid, out_ctrl and out_data are stable while out_valid=1 and out_ready=0; data must not change until consumed.
- Combinational paths: out_ready→in_ready and flush→{in_ready, out_valid, out_ctrl}. There is no other input-to-output path.
- rst asserted mid-stream takes effect at the next edge regardless of handshakes. In-flight data is lost, and outputs read the reset values in the following cycle.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, out_data=0, occupancy=0; after release in_ready=1.
- Streaming, DEPTH=2: in_valid=1, in_data=0x0001..0x0008, in_ctrl=4'hF, out_ready=1 → first out_valid two edges after the first accept. Outputs are 0x0001..0x0008 in order, one per cycle, and occupancy holds at 2 in steady state.
- Backpressure, DEPTH=2: after 0x0001 and 0x0002 are loaded, out_ready=0 for 5 cycles → in_ready=0, out_data=0x0001 stable, occupancy=2. Releasing gives 0x0001, 0x0002, 0x0003 with no loss or duplication.
- Bubble compression, DEPTH=3: out_ready=0, accept 0xAAAA, idle one cycle, accept 0xBBBB → 0xAAAA reaches the last stage; 0xBBBB packs directly behind it. occupancy=2, in_ready=1, and out_ctrl=0 is never seen while out_valid=1.
- Flush, DEPTH=2: occupancy=2, then flush=1 with in_valid=1, in_data=0xBEEF, out_ready=1 → that cycle out_valid=0, in_ready=0. Next cycle occupancy=0, out_ctrl=0, and 0xBEEF never appears.
- Reset mid-stall, DEPTH=2: full with out_ready=0, pulse rst for 1 cycle → next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1.
